reveal_engine: RTL and testbench



---
 rtl/reveal_engine.sv | 159 +++++++++++++++
 tb/tb_reveal_engine.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/reveal_engine.sv
// Minesweeper cell-reveal engine: checks the selected cell and its eight neighbours
// in the mine map and writes either a mine marker or the adjacent-mine count.
module reveal_engine (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic [31:0] blockID_data,
    output logic [7:0]  mine_addr,
    input  logic        mine_data,
    output logic        state_we,
    output logic [7:0]  state_addr,
    output logic [3:0]  state_data,
    output logic        busy,
    output logic        done,
    output logic        game_over
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_CTR  = 3'd1,
        ST_CHK_CTR = 3'd2,
        ST_RD_NBR  = 3'd3,
        ST_ACC_NBR = 3'd4,
        ST_WRITE   = 3'd5
    } state_t;

    state_t      state_r;
    logic        last_tog_r;
    logic [3:0]  row_r;
    logic [3:0]  col_r;
    logic [3:0]  count_r;
    logic [2:0]  k_r;
    logic        pending_s;
    logic        contrib_s;
    logic [8:0]  nbr_cur_s;
    logic [8:0]  nbr_next_s;
    logic        unused_s;

    // Returns {inbound, address}; out-of-bounds neighbours fall back to the center address.
    // A 5-bit sum of a 4-bit coordinate and -1/0/+1 lands in bit 4 exactly when it leaves 0..15.
    function automatic logic [8:0] nbr_lookup(input logic [3:0] row, input logic [3:0] col,
                                              input logic [2:0] k);
        logic [4:0] dr;
        logic [4:0] dc;
        logic [4:0] r5;
        logic [4:0] c5;
        case (k)
            3'd0:    begin dr = 5'h1F; dc = 5'h1F; end
            3'd1:    begin dr = 5'h1F; dc = 5'h00; end
            3'd2:    begin dr = 5'h1F; dc = 5'h01; end
            3'd3:    begin dr = 5'h00; dc = 5'h1F; end
            3'd4:    begin dr = 5'h00; dc = 5'h01; end
            3'd5:    begin dr = 5'h01; dc = 5'h1F; end
            3'd6:    begin dr = 5'h01; dc = 5'h00; end
            3'd7:    begin dr = 5'h01; dc = 5'h01; end
            default: begin dr = 5'h00; dc = 5'h00; end
        endcase
        r5 = {1'b0, row} + dr;
        c5 = {1'b0, col} + dc;
        if (!r5[4] && !c5[4]) begin
            return {1'b1, r5[3:0], c5[3:0]};
        end else begin
            return {1'b0, row, col};
        end
    endfunction

    assign pending_s  = blockID_data[9] ^ last_tog_r;
    assign nbr_cur_s  = nbr_lookup(row_r, col_r, k_r);
    assign nbr_next_s = nbr_lookup(row_r, col_r, k_r + 3'd1);
    assign contrib_s  = mine_data & nbr_cur_s[8];
    assign unused_s   = ^{blockID_data[31:10], blockID_data[8], nbr_next_s[8]};

    // Reveal sequencer; every output is registered and set on the edge entering its state.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state_r    <= ST_IDLE;
            last_tog_r <= 1'b0;
            row_r      <= 4'd0;
            col_r      <= 4'd0;
            count_r    <= 4'd0;
            k_r        <= 3'd0;
            mine_addr  <= 8'd0;
            state_we   <= 1'b0;
            state_addr <= 8'd0;
            state_data <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_we  <= 1'b0;
                    done      <= 1'b0;
                    game_over <= 1'b0;
                    if (pending_s) begin
                        row_r      <= blockID_data[7:4];
                        col_r      <= blockID_data[3:0];
                        last_tog_r <= blockID_data[9];
                        count_r    <= 4'd0;
                        k_r        <= 3'd0;
                        mine_addr  <= blockID_data[7:0];
                        busy       <= 1'b1;
                        state_r    <= ST_RD_CTR;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_RD_CTR: begin
                    state_r <= ST_CHK_CTR;
                end
                ST_CHK_CTR: begin
                    if (mine_data) begin
                        state_we   <= 1'b1;
                        state_addr <= {row_r, col_r};
                        state_data <= 4'd9;
                        done       <= 1'b1;
                        game_over  <= 1'b1;
                        state_r    <= ST_WRITE;
                    end else begin
                        mine_addr <= nbr_cur_s[7:0];
                        state_r   <= ST_RD_NBR;
                    end
                end
                ST_RD_NBR: begin
                    state_r <= ST_ACC_NBR;
                end
                ST_ACC_NBR: begin
                    count_r <= count_r + {3'b000, contrib_s};
                    if (k_r == 3'd7) begin
                        state_we   <= 1'b1;
                        state_addr <= {row_r, col_r};
                        state_data <= count_r + {3'b000, contrib_s};
                        done       <= 1'b1;
                        game_over  <= 1'b0;
                        state_r    <= ST_WRITE;
                    end else begin
                        k_r       <= k_r + 3'd1;
                        mine_addr <= nbr_next_s[7:0];
                        state_r   <= ST_RD_NBR;
                    end
                end
                ST_WRITE: begin
                    state_we  <= 1'b0;
                    done      <= 1'b0;
                    game_over <= 1'b0;
                    busy      <= 1'b0;
                    state_r   <= ST_IDLE;
                end
                default: begin
                    state_we  <= 1'b0;
                    done      <= 1'b0;
                    game_over <= 1'b0;
                    busy      <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reveal_engine.sv
// Scoreboard bench for reveal_engine: the driver queues expected writes, a negedge
// monitor pops and compares them whenever the engine strobes state_we.
module tb_reveal_engine;

    logic        clock = 1'b0;
    logic        ctrl_reset = 1'b1;
    logic [31:0] blockID_data = 32'd0;
    logic [7:0]  mine_addr;
    logic        mine_data = 1'b0;
    logic        state_we;
    logic [7:0]  state_addr;
    logic [3:0]  state_data;
    logic        busy;
    logic        done;
    logic        game_over;

    typedef struct {
        logic [7:0] addr;
        logic [3:0] data;
        logic       go;
        int         wcyc;
    } exp_t;

    exp_t q[$];
    logic mines[256];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   t0;

    reveal_engine dut (
        .clock(clock), .ctrl_reset(ctrl_reset), .blockID_data(blockID_data),
        .mine_addr(mine_addr), .mine_data(mine_data), .state_we(state_we),
        .state_addr(state_addr), .state_data(state_data), .busy(busy),
        .done(done), .game_over(game_over)
    );

    always #5 clock = ~clock;

    // Cycle index of the clock period currently running.
    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous-read mine map.
    always @(posedge clock) mine_data <= mines[mine_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pulse consistency every cycle, scoreboard pop on every write.
    always @(negedge clock) begin
        exp_t e;
        if (!ctrl_reset) begin
            check("done_eq_we", {31'd0, done}, {31'd0, state_we});
            if (game_over === 1'b1) check("gameover_needs_we", {31'd0, state_we}, 32'd1);
            if (state_we === 1'b1) begin
                if (q.size() == 0) begin
                    check("unexpected_write", {24'd0, state_addr}, 32'hFFFF_FFFF);
                end else begin
                    e = q.pop_front();
                    check("wr_addr", {24'd0, state_addr}, {24'd0, e.addr});
                    check("wr_data", {28'd0, state_data}, {28'd0, e.data});
                    check("wr_gameover", {31'd0, game_over}, {31'd0, e.go});
                    check("wr_cycle", cyc, e.wcyc);
                    check("wr_busy", {31'd0, busy}, 32'd1);
                end
            end
        end
    end

    task automatic clear_mines();
        for (int i = 0; i < 256; i++) mines[i] = 1'b0;
    endtask

    // Present a request during the current cycle and queue its expected write.
    task automatic request(input logic [3:0] r, input logic [3:0] c, input logic tog,
                           input logic [3:0] data, input logic go, input int acc);
        exp_t e;
        blockID_data = {22'd0, tog, 1'b0, r, c};
        e.addr = {r, c};
        e.data = data;
        e.go   = go;
        e.wcyc = acc + (go ? 3 : 19);
        q.push_back(e);
    endtask

    task automatic wait_idle();
        int ok = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            if (busy === 1'b0 && q.size() == 0) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mine_addr"}, {24'd0, mine_addr}, 32'd0);
        check({tag, "_state_we"}, {31'd0, state_we}, 32'd0);
        check({tag, "_state_addr"}, {24'd0, state_addr}, 32'd0);
        check({tag, "_state_data"}, {28'd0, state_data}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_game_over"}, {31'd0, game_over}, 32'd0);
    endtask

    initial begin
        clear_mines();
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        ctrl_reset = 1'b0;
        @(negedge clock);

        // Corner (0,0): two in-bound mines.
        mines[8'h01] = 1'b1;
        mines[8'h11] = 1'b1;
        t0 = cyc;
        request(4'd0, 4'd0, 1'b1, 4'd2, 1'b0, t0);
        repeat (3) @(negedge clock);
        check("corner_k0_addr", {24'd0, mine_addr}, 32'h00);
        repeat (8) @(negedge clock);
        check("corner_k4_addr", {24'd0, mine_addr}, 32'h01);
        wait_idle();

        // (5,5) fully surrounded.
        clear_mines();
        mines[8'h44] = 1'b1; mines[8'h45] = 1'b1; mines[8'h46] = 1'b1; mines[8'h54] = 1'b1;
        mines[8'h56] = 1'b1; mines[8'h64] = 1'b1; mines[8'h65] = 1'b1; mines[8'h66] = 1'b1;
        t0 = cyc;
        request(4'd5, 4'd5, 1'b0, 4'd8, 1'b0, t0);
        @(negedge clock);
        check("c55_center_addr", {24'd0, mine_addr}, 32'h55);
        check("c55_busy_t1", {31'd0, busy}, 32'd1);
        repeat (2) @(negedge clock);
        check("c55_k0_addr", {24'd0, mine_addr}, 32'h44);
        repeat (14) @(negedge clock);
        check("c55_k7_addr", {24'd0, mine_addr}, 32'h66);
        repeat (3) @(negedge clock);
        check("c55_busy_after", {31'd0, busy}, 32'd0);
        wait_idle();

        // (3,7) is a mine.
        clear_mines();
        mines[8'h37] = 1'b1;
        t0 = cyc;
        request(4'd3, 4'd7, 1'b1, 4'd9, 1'b1, t0);
        @(negedge clock);
        check("mine_center_addr", {24'd0, mine_addr}, 32'h37);
        repeat (3) @(negedge clock);
        check("mine_go_cleared", {31'd0, game_over}, 32'd0);
        check("mine_done_cleared", {31'd0, done}, 32'd0);
        check("mine_busy_after", {31'd0, busy}, 32'd0);
        wait_idle();

        // (15,15) empty, then a new coordinate with the same toggle is ignored.
        clear_mines();
        t0 = cyc;
        request(4'd15, 4'd15, 1'b0, 4'd0, 1'b0, t0);
        wait_idle();
        blockID_data = {22'd0, 1'b0, 1'b0, 4'd4, 4'd4};
        repeat (25) @(negedge clock);
        check("same_tog_busy", {31'd0, busy}, 32'd0);
        check("same_tog_addr_hold", {24'd0, mine_addr}, 32'hFF);

        // (2,15): wrap-around positions are mined but must not count.
        clear_mines();
        mines[8'h1E] = 1'b1; mines[8'h10] = 1'b1; mines[8'h20] = 1'b1; mines[8'h30] = 1'b1;
        t0 = cyc;
        request(4'd2, 4'd15, 1'b1, 4'd1, 1'b0, t0);
        wait_idle();

        // (0,15): top row out of bounds.
        t0 = cyc;
        request(4'd0, 4'd15, 1'b0, 4'd1, 1'b0, t0);
        wait_idle();

        // Toggle flipped mid-request: second request waits for the IDLE cycle after WRITE.
        clear_mines();
        mines[8'h77] = 1'b1;
        mines[8'h9A] = 1'b1;
        t0 = cyc;
        request(4'd8, 4'd8, 1'b1, 4'd1, 1'b0, t0);
        repeat (5) @(negedge clock);
        request(4'd9, 4'd9, 1'b0, 4'd1, 1'b0, t0 + 20);
        wait_idle();

        // Reset mid-request, then restart with bit 9 still high.
        clear_mines();
        mines[8'h44] = 1'b1; mines[8'h45] = 1'b1; mines[8'h46] = 1'b1; mines[8'h54] = 1'b1;
        mines[8'h56] = 1'b1; mines[8'h64] = 1'b1; mines[8'h65] = 1'b1; mines[8'h66] = 1'b1;
        blockID_data = {22'd0, 1'b1, 1'b0, 4'd5, 4'd5};
        repeat (10) @(negedge clock);
        ctrl_reset = 1'b1;
        #1;
        check_all_zero("midreset");
        repeat (3) @(negedge clock);
        ctrl_reset = 1'b0;
        request(4'd5, 4'd5, 1'b1, 4'd8, 1'b0, cyc);
        wait_idle();
        repeat (3) @(negedge clock);
        check("hold_state_addr", {24'd0, state_addr}, 32'h55);
        check("hold_state_data", {28'd0, state_data}, 32'd8);
        check("queue_drained", q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
